// File: rtl/proc_pkg.sv
// Shared processor definitions: default address width and PC-stage states.
package proc_pkg;

   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_HALT  = 2'b01,
      ST_FAULT = 2'b10
   } pc_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Error handling lives in the caller, which gates wr_en/rd_en.
module ret_stack
   import proc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 8,
   localparam int IW    = $clog2(DEPTH),
   localparam int SP_W  = IW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] top,
   output logic [SP_W-1:0]   sp,
   output logic              full,
   output logic              empty
);

   logic [ADDR_W-1:0] r_mem [DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic [SP_W-1:0]   w_spm1;

   assign w_spm1 = r_sp - SP_W'(1);
   assign top    = r_mem[w_spm1[IW-1:0]];
   assign sp     = r_sp;
   assign full   = (r_sp == SP_W'(DEPTH));
   assign empty  = (r_sp == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp <= '0;
      end else if (rd_en) begin
         r_sp <= w_spm1;
      end else if (wr_en) begin
         r_sp <= r_sp + SP_W'(1);
      end
   end

   // RAM contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en && !rd_en && !reset) begin
         r_mem[r_sp[IW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/pc_stack_unit.sv
// PC register, next-PC mux and RUN/HALT/FAULT control around the return stack.
// Optional PC_STALL_EN adds a stall input that freezes the stage while in RUN.
module pc_stack_unit
   import proc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
`ifdef PC_STALL_EN
   input  logic              stall,
`endif
   input  logic              pc_src,
   input  logic              push,
   input  logic              pop,
   input  logic              halt,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              overflow_err,
   output logic              underflow_err
);

   localparam int SP_W = $clog2(DEPTH) + 1;

   pc_state_t         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_top;
   logic              r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
   logic              w_wr, w_rd, w_stall;
   logic [SP_W-1:0]   w_sp;

`ifdef PC_STALL_EN
   assign w_stall = stall;
`else
   assign w_stall = 1'b0;
`endif

   assign w_pc_inc = r_pc + ADDR_W'(1);

   ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_stack (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr),
      .wr_data (w_pc_inc),
      .rd_en   (w_rd),
      .top     (w_top),
      .sp      (w_sp),
      .full    (stack_full),
      .empty   (stack_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ovf_nxt   = r_ovf;
      w_unf_nxt   = r_unf;
      w_wr        = 1'b0;
      w_rd        = 1'b0;
      if (r_state == ST_RUN && !w_stall && !reset) begin
         if (halt) begin
            w_state_nxt = ST_HALT;
         end else if (pop) begin
            if (w_sp != '0) begin
               w_rd     = 1'b1;
               w_pc_nxt = w_top;
            end else begin
               w_unf_nxt   = 1'b1;
               w_state_nxt = ST_FAULT;
            end
         end else if (push) begin
            if (w_sp < SP_W'(DEPTH)) begin
               w_wr     = 1'b1;
               w_pc_nxt = branch_target;
            end else begin
               w_ovf_nxt   = 1'b1;
               w_state_nxt = ST_FAULT;
            end
         end else if (pc_src) begin
            w_pc_nxt = branch_target;
         end else begin
            w_pc_nxt = w_pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_pc    <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end
   end

   assign pc            = r_pc;
   assign halted        = (r_state != ST_RUN);
   assign overflow_err  = r_ovf;
   assign underflow_err = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;

   localparam int AW = 16;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          pc_src = 1'b0, push = 1'b0, pop = 1'b0, halt = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic [AW-1:0] pc;
   logic          halted, stack_full, stack_empty;
   logic          overflow_err, underflow_err;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stk[$];
   int            m_st;
   logic          m_ovf, m_unf;

   pc_stack_unit #(.ADDR_W(AW), .DEPTH(DP)) dut (
      .clk           (clk),
      .reset         (reset),
`ifdef PC_STALL_EN
      .stall         (stall),
`endif
      .pc_src        (pc_src),
      .push          (push),
      .pop           (pop),
      .halt          (halt),
      .branch_target (branch_target),
      .pc            (pc),
      .halted        (halted),
      .stack_full    (stack_full),
      .stack_empty   (stack_empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic ps, input logic pu,
                       input logic po, input logic h,
                       input logic [AW-1:0] bt, input logic st);
      logic eff_st;
      reset = r; pc_src = ps; push = pu; pop = po; halt = h;
      branch_target = bt;
`ifdef PC_STALL_EN
      stall = st;
      eff_st = st;
`else
      stall = 1'b0;
      eff_st = 1'b0 & st;
`endif
      @(posedge clk);
      if (r) begin
         m_pc = '0; m_stk.delete(); m_st = 0; m_ovf = 0; m_unf = 0;
      end else if (m_st == 0 && !eff_st) begin
         if (h) m_st = 1;
         else if (po) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_unf = 1; m_st = 2; end
         end else if (pu) begin
            if (m_stk.size() < DP) begin
               m_stk.push_back(m_pc + 16'd1);
               m_pc = bt;
            end else begin m_ovf = 1; m_st = 2; end
         end else if (ps) m_pc = bt;
         else m_pc = m_pc + 16'd1;
      end
      #1;
   endtask

   task automatic test_reset;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0 || halted !== 1'b0 || stack_empty !== 1'b1 ||
          stack_full !== 1'b0 || overflow_err !== 1'b0 ||
          underflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: pc=%h h=%b f=%b e=%b o=%b u=%b", pc, halted,
                  stack_full, stack_empty, overflow_err, underflow_err);
      end
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 0, 0, 0, 16'h0, 0);
         n_cmp++;
         if (pc !== AW'(i) || stack_empty !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL idle%0d: pc=%h e=%b h=%b want pc=%h e=1 h=0",
                     i, pc, stack_empty, halted, AW'(i));
         end
      end
   endtask

   task automatic test_call_ret;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 1, 0, 0, 0, 16'h0010, 0);
      step(0, 0, 1, 0, 0, 16'h0040, 0);
      n_cmp++;
      if (pc !== 16'h0040 || stack_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL call: pc=%h e=%b want 0040 e=0", pc, stack_empty);
      end
      step(0, 0, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0041) begin
         n_fail++;
         $display("FAIL call_idle: pc=%h want 0041", pc);
      end
      step(0, 0, 0, 1, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0011 || stack_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL ret: pc=%h e=%b want 0011 e=1", pc, stack_empty);
      end
      // push and pop together: pop wins on an empty stack -> underflow
      step(0, 0, 1, 1, 0, 16'h0099, 0);
      n_cmp++;
      if (underflow_err !== 1'b1 || overflow_err !== 1'b0 || pc !== 16'h0011) begin
         n_fail++;
         $display("FAIL pushpop: u=%b o=%b pc=%h want u=1 o=0 pc=0011",
                  underflow_err, overflow_err, pc);
      end
   endtask

   task automatic test_overflow;
      logic [AW-1:0] frz;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < DP; i++)
         step(0, 0, 1, 0, 0, AW'($urandom), 0);
      n_cmp++;
      if (stack_full !== 1'b1 || pc !== m_pc) begin
         n_fail++;
         $display("FAIL full: f=%b pc=%h want f=1 pc=%h", stack_full, pc, m_pc);
      end
      frz = m_pc;
      step(0, 0, 1, 0, 0, 16'h1234, 0);
      n_cmp++;
      if (overflow_err !== 1'b1 || halted !== 1'b1 || pc !== frz) begin
         n_fail++;
         $display("FAIL ovf: o=%b h=%b pc=%h want o=1 h=1 pc=%h",
                  overflow_err, halted, pc, frz);
      end
      for (int i = 0; i < 20; i++)
         step(0, i[0], 0, 0, 0, AW'($urandom), 0);
      n_cmp++;
      if (pc !== frz || halted !== 1'b1 || stack_full !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_frozen: pc=%h h=%b f=%b want pc=%h h=1 f=1",
                  pc, halted, stack_full, frz);
      end
   endtask

   task automatic test_underflow;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 1, 0, 16'h0, 0);
      n_cmp++;
      if (underflow_err !== 1'b1 || halted !== 1'b1 || pc !== 16'h0) begin
         n_fail++;
         $display("FAIL unf: u=%b h=%b pc=%h want u=1 h=1 pc=0000",
                  underflow_err, halted, pc);
      end
      step(1, 0, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0 || halted !== 1'b0 || stack_empty !== 1'b1 ||
          stack_full !== 1'b0 || overflow_err !== 1'b0 ||
          underflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_reset: pc=%h h=%b e=%b u=%b want reset values",
                  pc, halted, stack_empty, underflow_err);
      end
   endtask

   task automatic test_wrap_halt;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 1, 0, 0, 0, 16'hFFFF, 0);
      step(0, 0, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap: pc=%h want 0000", pc);
      end
      // a call from 0xFFFF saves a wrapped return address of 0x0000
      step(0, 1, 0, 0, 0, 16'hFFFF, 0);
      step(0, 0, 1, 0, 0, 16'h0200, 0);
      step(0, 0, 0, 1, 0, 16'h0, 0);
      n_cmp++;
      if (pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_ret: pc=%h want 0000", pc);
      end
      step(0, 1, 0, 0, 1, 16'h0123, 0);
      n_cmp++;
      if (halted !== 1'b1 || pc !== 16'h0000 || overflow_err !== 1'b0 ||
          underflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL halt: h=%b pc=%h want h=1 pc=0000", halted, pc);
      end
      step(0, 0, 1, 0, 0, 16'h0321, 0);
      n_cmp++;
      if (halted !== 1'b1 || pc !== 16'h0000 || stack_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_frozen: h=%b pc=%h e=%b want h=1 pc=0000 e=1",
                  halted, pc, stack_empty);
      end
   endtask

`ifdef PC_STALL_EN
   task automatic test_stall;
      logic [AW-1:0] p0;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 1, 0, 0, 0, 16'h0050, 0);
      p0 = pc;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 0, 16'h0300, 1);
         n_cmp++;
         if (pc !== p0 || stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stall%0d: pc=%h e=%b want pc=%h e=1",
                     i, pc, stack_empty, p0);
         end
      end
      step(0, 0, 1, 0, 0, 16'h0300, 0);
      n_cmp++;
      if (pc !== 16'h0300 || stack_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL unstall: pc=%h e=%b want 0300 e=0", pc, stack_empty);
      end
   endtask
`endif

   task automatic test_random;
      logic r, ps, pu, po, h, st;
      step(1, 0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 400; i++) begin
         r  = (m_st != 0) ? ($urandom_range(0, 3) == 0)
                          : ($urandom_range(0, 60) == 0);
         ps = $urandom_range(0, 2) == 0;
         pu = $urandom_range(0, 3) == 0;
         po = $urandom_range(0, 4) == 0;
         h  = $urandom_range(0, 40) == 0;
         st = $urandom_range(0, 5) == 0;
         step(r, ps, pu, po, h, AW'($urandom), st);
         n_cmp++;
         if (pc !== m_pc || halted !== (m_st != 0) ||
             stack_full !== (m_stk.size() == DP) ||
             stack_empty !== (m_stk.size() == 0) ||
             overflow_err !== m_ovf || underflow_err !== m_unf) begin
            n_fail++;
            $display("FAIL rand%0d: pc=%h h=%b f=%b e=%b o=%b u=%b want pc=%h h=%b sz=%0d o=%b u=%b",
                     i, pc, halted, stack_full, stack_empty, overflow_err,
                     underflow_err, m_pc, m_st != 0, m_stk.size(), m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      m_pc = '0; m_st = 0; m_ovf = 0; m_unf = 0;
      test_reset();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_wrap_halt();
`ifdef PC_STALL_EN
      test_stall();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
